// File: rtl/mips_mem_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : mips_mem_pkg                                                    |
// | Purpose  : Shared size codes, FSM encodings and lane count for the MEM     |
// |            stage data memory.                                              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package mips_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int c_NUM_LANES = 4;
endpackage

`default_nettype wire

// File: rtl/dmem_load_align.sv
// +----------------------------------------------------------------------------+
// | Module   : dmem_load_align                                                 |
// | Purpose  : Selects the addressed byte/halfword of a memory word and        |
// |            sign- or zero-extends it to 32 bits.                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    // Halfword offset[0] is always 0 here; misaligned halves are squashed upstream.
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = i_word;
    case (i_size)
      SZ_BYTE: o_data = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: o_data = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : data_mem_ctrl                                                   |
// | Purpose  : MEM-stage data memory with byte/half/word access, registered    |
// |            extended loads, misalign detection and post-reset clear sweep. |
// |            Define DMEM_BYPASS_EN for write-to-read forwarding.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int INIT_CLEAR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Mem_Write_M,
  input  logic        Mem_Read_M,
  input  logic [1:0]  Mem_Size_M,
  input  logic        Mem_Unsigned_M,
  input  logic [31:0] ALU_result_M,
  input  logic [31:0] Write_Data_M,
  output logic [31:0] Mem_Read_Data_M,
  output logic        Read_Valid_M,
  output logic        Misalign_Err_M,
  output logic        Busy_M
);

  localparam int              c_DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(c_DEPTH - 1);
  localparam logic [0:0]      c_ST_RST = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [31:0]       r_mem [c_DEPTH];

  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_off;
  logic [1:0]        w_size;
  logic              w_misalign;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic [3:0]        w_strb;
  logic [31:0]       w_wdata;
  logic [31:0]       w_old;
  logic [31:0]       w_new;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_load;
  logic              w_unused_addr;

  assign w_idx         = ALU_result_M[ADDR_W+1:2];
  assign w_off         = ALU_result_M[1:0];
  assign w_unused_addr = ^ALU_result_M[31:ADDR_W+2];
  assign w_size        = (Mem_Size_M == 2'b11) ? SZ_WORD : Mem_Size_M;

  always_comb begin
    w_misalign = 1'b0;
    w_strb     = 4'hF;
    w_wdata    = Write_Data_M;
    case (w_size)
      SZ_BYTE: begin
        w_strb  = 4'b0001 << w_off;
        w_wdata = {4{Write_Data_M[7:0]}};
      end
      SZ_HALF: begin
        w_misalign = w_off[0];
        w_strb     = 4'b0011 << w_off;
        w_wdata    = {2{Write_Data_M[15:0]}};
      end
      default: w_misalign = (w_off != 2'b00);
    endcase
  end

  assign w_wr_ok = !Busy_M && Mem_Write_M && !w_misalign;
  assign w_rd_ok = !Busy_M && Mem_Read_M;
  assign w_old   = r_mem[w_idx];

  // Post-store word: new lanes merged over the old ones.
  for (genvar l = 0; l < c_NUM_LANES; l++) begin : g_lane
    assign w_new[8*l +: 8] = w_strb[l] ? w_wdata[8*l +: 8] : w_old[8*l +: 8];
  end

`ifdef DMEM_BYPASS_EN
  assign w_rd_word = w_wr_ok ? w_new : w_old;
`else
  assign w_rd_word = w_old;
`endif

  dmem_load_align u_align (
    .i_word     (w_rd_word),
    .i_offset   (w_off),
    .i_size     (w_size),
    .i_unsigned (Mem_Unsigned_M),
    .o_data     (w_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_ST_RST;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_clr_cnt == c_LAST) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    Busy_M = (r_state == ST_INIT);
  end

  always_ff @(posedge clk) begin
    if (Busy_M) r_mem[r_clr_cnt] <= '0;
    else if (w_wr_ok) r_mem[w_idx] <= w_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Mem_Read_Data_M <= '0;
      Read_Valid_M    <= 1'b0;
      Misalign_Err_M  <= 1'b0;
    end else begin
      Read_Valid_M    <= w_rd_ok;
      Mem_Read_Data_M <= (w_rd_ok && !w_misalign) ? w_load : 32'd0;
      Misalign_Err_M  <= !Busy_M && (Mem_Read_M || Mem_Write_M) && w_misalign;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// Directed scoreboard bench for data_mem_ctrl (ADDR_W=4, INIT_CLEAR=1).
`default_nettype none

module tb_data_mem_ctrl;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Mem_Write_M = 1'b0;
  logic        Mem_Read_M = 1'b0;
  logic [1:0]  Mem_Size_M = 2'b00;
  logic        Mem_Unsigned_M = 1'b0;
  logic [31:0] ALU_result_M = '0;
  logic [31:0] Write_Data_M = '0;
  logic [31:0] Mem_Read_Data_M;
  logic        Read_Valid_M;
  logic        Misalign_Err_M;
  logic        Busy_M;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  data_mem_ctrl #(.ADDR_W(4), .INIT_CLEAR(1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Mem_Write_M     (Mem_Write_M),
    .Mem_Read_M      (Mem_Read_M),
    .Mem_Size_M      (Mem_Size_M),
    .Mem_Unsigned_M  (Mem_Unsigned_M),
    .ALU_result_M    (ALU_result_M),
    .Write_Data_M    (Write_Data_M),
    .Mem_Read_Data_M (Mem_Read_Data_M),
    .Read_Valid_M    (Read_Valid_M),
    .Misalign_Err_M  (Misalign_Err_M),
    .Busy_M          (Busy_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Mem_Write_M = 1'b0;
    Mem_Read_M  = 1'b0;
  endtask

  // Drive one request cycle; exp_data is queued when a result is expected.
  task automatic req(input string tag, input logic wr, input logic rd, input logic [1:0] sz,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] e;
    Mem_Write_M    = wr;
    Mem_Read_M     = rd;
    Mem_Size_M     = sz;
    Mem_Unsigned_M = uns;
    ALU_result_M   = addr;
    Write_Data_M   = wdata;
    if (rd) exp_q.push_back(exp_data);
    @(posedge clk);
    #1;
    idle();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, {31'd0, Read_Valid_M}, 32'd1);
      chk({tag, "_data"}, Mem_Read_Data_M, e);
    end else begin
      chk({tag, "_valid"}, {31'd0, Read_Valid_M}, 32'd0);
      chk({tag, "_data"}, Mem_Read_Data_M, 32'd0);
    end
    chk({tag, "_err"}, {31'd0, Misalign_Err_M}, {31'd0, exp_err});
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (Busy_M === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, n, 32'd16);
  endtask

  initial begin
    logic [31:0] same_exp;
`ifdef DMEM_BYPASS_EN
    same_exp = 32'h12345678;
`else
    same_exp = 32'h11111111;
`endif
    // Reset state
    #12;
    chk("rst_busy", {31'd0, Busy_M}, 32'd1);
    chk("rst_valid", {31'd0, Read_Valid_M}, 32'd0);
    chk("rst_data", Mem_Read_Data_M, 32'd0);
    chk("rst_err", {31'd0, Misalign_Err_M}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Read during the sweep is ignored; busy lasts 16 cycles in total
    Mem_Read_M = 1'b1; Mem_Size_M = SZ_WORD; ALU_result_M = 32'h8;
    @(posedge clk);
    #1;
    idle();
    chk("busy_rd_valid", {31'd0, Read_Valid_M}, 32'd0);
    chk("busy_rd_err", {31'd0, Misalign_Err_M}, 32'd0);
    begin
      int n = 1;
      while (Busy_M === 1'b1 && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("busy_len", n, 32'd16);
    end
    req("clr_rd8", 0, 1, SZ_WORD, 0, 32'h8, 0, 32'h0, 0);

    // Word store then byte store
    req("st_w4", 1, 0, SZ_WORD, 0, 32'h4, 32'hA1B2C3D4, 0, 0);
    req("st_b5", 1, 0, SZ_BYTE, 0, 32'h5, 32'h000000EE, 0, 0);
    req("ld_w4", 0, 1, SZ_WORD, 0, 32'h4, 0, 32'hA1B2EED4, 0);

    // Extension
    req("st_w10", 1, 0, SZ_WORD, 0, 32'h10, 32'h000080F0, 0, 0);
    req("ld_hs", 0, 1, SZ_HALF, 0, 32'h10, 0, 32'hFFFF80F0, 0);
    req("ld_hu", 0, 1, SZ_HALF, 1, 32'h10, 0, 32'h000080F0, 0);
    req("ld_bs", 0, 1, SZ_BYTE, 0, 32'h10, 0, 32'hFFFFFFF0, 0);
    req("ld_bu11", 0, 1, SZ_BYTE, 1, 32'h11, 0, 32'h00000080, 0);
    req("ld_bs11", 0, 1, SZ_BYTE, 0, 32'h11, 0, 32'hFFFFFF80, 0);
    req("ld_hs12", 0, 1, SZ_HALF, 0, 32'h12, 0, 32'h00000000, 0);
    req("ld_sz3", 0, 1, 2'b11, 0, 32'h10, 0, 32'h000080F0, 0);
    req("ld_b7", 0, 1, SZ_BYTE, 1, 32'h7, 0, 32'h000000A1, 0);
    req("ld_h6", 0, 1, SZ_HALF, 1, 32'h6, 0, 32'h0000A1B2, 0);

    // Misaligned accesses
    req("mis_st6", 1, 0, SZ_WORD, 0, 32'h6, 32'hDEADBEEF, 0, 1);
    req("mis_chk4", 0, 1, SZ_WORD, 0, 32'h4, 0, 32'hA1B2EED4, 0);
    req("mis_ld3", 0, 1, SZ_HALF, 0, 32'h3, 0, 32'h0, 1);
    req("mis_st_sz3", 1, 0, 2'b11, 0, 32'h11, 32'h0, 0, 1);
    req("mis_chk10", 0, 1, SZ_WORD, 0, 32'h10, 0, 32'h000080F0, 0);

    // Same-cycle read and write
    req("st_w20", 1, 0, SZ_WORD, 0, 32'h20, 32'h11111111, 0, 0);
    req("rw_w20", 1, 1, SZ_WORD, 0, 32'h20, 32'h12345678, same_exp, 0);
    req("ld_w20", 0, 1, SZ_WORD, 0, 32'h20, 0, 32'h12345678, 0);

    // Aliasing
    req("st_w44", 1, 0, SZ_WORD, 0, 32'h44, 32'hCAFEF00D, 0, 0);
    req("ld_alias", 0, 1, SZ_WORD, 0, 32'h04, 0, 32'hCAFEF00D, 0);

    // Pending result discarded by asynchronous reset
    Mem_Read_M = 1'b1; Mem_Size_M = SZ_WORD; ALU_result_M = 32'h4;
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, Read_Valid_M}, 32'd0);
    chk("arst_data", Mem_Read_Data_M, 32'd0);
    chk("arst_busy", {31'd0, Busy_M}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("mid_busy_pre", {31'd0, Busy_M}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy_rst", {31'd0, Busy_M}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    count_busy("mid_busy_len");
    req("post_clr4", 0, 1, SZ_WORD, 0, 32'h4, 0, 32'h0, 0);
    req("post_clr20", 0, 1, SZ_WORD, 0, 32'h20, 0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised successor to the single-word pipeline data memory in the MIPS MEM stage. It adds:
- byte, halfword and word accesses with per-lane write strobes;
- sign or zero extension on loads;
- a registered 1-cycle read with a valid flag;
- misaligned-access detection;
- a post-reset clear sweep that zeroes the array.

It sits between the EX/MEM pipeline register and the MEM/WB register.

Parameters:
ADDR_W, 4, word-index bits; DEPTH = 2**ADDR_W words of 32 bits.
INIT_CLEAR, 1, 1 = zero every word after reset before accepting accesses; 0 = accept accesses immediately, array contents undefined.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
Mem_Write_M  in  1  store request this cycle
Mem_Read_M  in  1  load request this cycle
Mem_Size_M  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
Mem_Unsigned_M  in  1  1 = zero-extend load, 0 = sign-extend
ALU_result_M  in  32  byte address
Write_Data_M  in  32  store data, right-justified
Mem_Read_Data_M  out  32  extended load data, registered
Read_Valid_M  out  1  Mem_Read_Data_M is valid this cycle
Misalign_Err_M  out  1  one-cycle pulse: previous-cycle request was misaligned
Busy_M  out  1  clear sweep in progress; requests ignored

Behaviour:
- Address split:
  - word index = ALU_result_M[ADDR_W+1:2]; byte offset = ALU_result_M[1:0].
  - Higher address bits are ignored, so addresses alias modulo 4*DEPTH.
- Reset (rst_n low, asynchronous):
  - Mem_Read_Data_M=0, Read_Valid_M=0, Misalign_Err_M=0.
  - Busy_M=1 if INIT_CLEAR else 0.
  - Clear counter=0; state=INIT if INIT_CLEAR else RUN.
  - The array itself is not reset.
- FSM states: INIT, RUN.
  - INIT: writes 0 to word[counter] each cycle and increments the counter; Busy_M=1.
  - INIT to RUN: after writing word DEPTH-1, i.e. Busy_M falls on the edge DEPTH cycles after reset release.
  - INIT requests: read/write requests are ignored (no write, no Read_Valid_M, no Misalign_Err_M).
  - RUN: terminal until reset.
  - Reset mid-sweep or mid-access: restart INIT from counter 0; any pending read result is discarded.
- Alignment:
  - Half with offset[0]=1, or word with offset!=0, is misaligned.
  - A misaligned request performs no write.
  - A misaligned read returns Mem_Read_Data_M=0 with Read_Valid_M=1.
  - Misalign_Err_M=1 in the cycle after any misaligned read or write.
- Store (RUN, aligned, Mem_Write_M=1), committed at the rising edge:
  - byte: Write_Data_M[7:0] goes to lane offset.
  - half: Write_Data_M[15:0] goes to lanes offset, offset+1.
  - word: all 4 lanes.
  - Lane 0 = bits [7:0] (little-endian).
- Load (RUN, Mem_Read_M=1 in cycle N):
  - In cycle N+1: Read_Valid_M=1 and Mem_Read_Data_M holds the selected lane(s), extended per Mem_Unsigned_M.
  - For word loads, extension is a no-op.
  - In any cycle without a valid read: Read_Valid_M=0 and Mem_Read_Data_M=0.
  - Back-to-back reads give one result per cycle.
- Read and write in the same cycle, same word: read-before-write, so the load returns the old contents (unless DMEM_BYPASS_EN).
- Read and write in the same cycle, different words: both proceed independently.
- Mem_Size_M=11 behaves exactly as 10.

Optional Feature:
- DMEM_BYPASS_EN defined:
  - A same-cycle aligned read and write to the same word returns the post-write word (store lanes merged over old lanes), then extracts and extends it.
  - Reads in a cycle after a write already see the new data.
- Not defined: read-before-write as above.

Decomposition:
- Shared package mips_mem_pkg holds:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encodings ST_INIT, ST_RUN;
  - lane-count constant 4.
- One combinational sub-module dmem_load_align: inputs are the 32-bit word, offset, size and unsigned; output is the extended 32-bit load data. It is instantiated once on the read path.

Test Plan:
1. INIT_CLEAR=1, ADDR_W=4, release rst_n -> Busy_M=1 for exactly 16 cycles. A read of 0x8 issued during Busy_M produces no Read_Valid_M. After Busy_M falls, a word read of 0x8 returns 0x00000000.
2. Word store 0xA1B2C3D4 at 0x4, then byte store 0xEE at 0x5 -> word read at 0x4 returns 0xA1B2EED4, one cycle after the request.
3. Store 0x000080F0 at 0x10, then:
   - signed half load at 0x10 -> 0xFFFF80F0;
   - unsigned half load at 0x10 -> 0x000080F0;
   - signed byte load at 0x10 -> 0xFFFFFFF0.
4. Word store at 0x6 -> Misalign_Err_M=1 for one cycle and the memory is unchanged. Half read at 0x3 -> Read_Valid_M=1, data 0, Misalign_Err_M=1.
5. Same-cycle word write 0x12345678 and word read at 0x20, old contents 0x11111111 -> returns 0x11111111 without DMEM_BYPASS_EN, 0x12345678 with it.
6. Aliasing and reset:
   - Store at 0x44 (ADDR_W=4) -> read at 0x04 returns that value.
   - Assert rst_n low mid-sweep -> Busy_M stays 1 and the sweep restarts from 0; a full 16-cycle sweep follows the release.
